pixel_word_packer: RTL and testbench
====================================

// Module: pixel_word_packer
// PURPOSE
//  Packs a narrow pixel stream (camera/pattern side) into 128-bit words for the DDR3
//  write AXIS FIFO that feeds the MIG read/write looper. Runs in the writer's domain;
//  the CDC FIFO sits downstream. tuser marks the word holding a frame's first pixel.
//  A frame start arriving mid-word forces a zero-padded flush so frames stay word-aligned.
// PARAMETERS
//  PIXEL_WIDTH  16   bits per input pixel; must divide WORD_WIDTH
//  WORD_WIDTH   128  output word width (MIG app data width)
//  LANES        WORD_WIDTH/PIXEL_WIDTH (localparam, 8 at defaults)
// PORTS
//  clk_in             in   1    clock
//  rst_n_in           in   1    async active-low reset
//  pixel_data_in      in   PW   pixel, lane order LSB-first
//  pixel_tuser_in     in   1    first pixel of frame
//  pixel_valid_in     in   1    pixel present
//  pixel_ready_out    out  1    packer accepts pixel this cycle
//  word_axis_data     out  WW   packed word
//  word_axis_tuser    out  1    word contains frame-start pixel (lane 0)
//  word_axis_valid    out  1    word present
//  word_axis_ready    in   1    downstream accepts word
//  flush_count_out    out  16   partial words padded due to mid-word tuser, saturating
//  word_count_out     out  32   words issued since reset, wraps
// BEHAVIOUR
//  Reset (async assert, sync release): lane_cnt=0, accumulator=0, acc_tuser=0,
//   word_axis_valid=0, data=0, tuser=0, both counters=0; pixel_ready_out=0 during reset.
//  Pixel accept = pixel_valid_in && pixel_ready_out. Word handoff = valid && ready.
//  out_free = !word_axis_valid || word_axis_ready (output register empty or draining).
//  Normal accept: pixel written to lane lane_cnt (bits [lane*PW +: PW]); lane_cnt++.
//   Lane 0 accept latches acc_tuser = pixel_tuser_in.
//  Complete: accept into lane LANES-1 -> word (with acc_tuser) loads output register
//   the SAME cycle, lane_cnt->0, accumulator cleared. Latency: last pixel accept ->
//   word_axis_valid next cycle. Requires out_free; else pixel_ready_out=0.
//  Flush: accept with pixel_tuser_in=1 and lane_cnt!=0 -> partial word (unused lanes
//   zero, acc_tuser kept) loads output register; new pixel to lane 0, acc_tuser=1,
//   lane_cnt=1; flush_count++ (saturate at 16'hFFFF). Requires out_free.
//  pixel_ready_out = rst released && (out_free || (lane_cnt!=LANES-1 && !pixel_tuser_in)
//   || (lane_cnt==0)) -- i.e. only stalls when the accept would emit a word.
//   Combinational from word_axis_ready/pixel_tuser_in; no ready->valid loop upstream.
//  tuser on lane 0 with lane_cnt==0: no flush, just sets acc_tuser.
//  Output register holds data/tuser stable while valid && !ready (AXIS rules);
//   valid never drops without handoff.
//  word_count_out increments on every handoff, wraps at 2^32.
//  No mid-frame partial flush on idle: pixels stay buffered until word completes or tuser.
//  Reset mid-word discards accumulator and any pending output word.
// STRUCTURE
//  pixel_pack_pkg: LANES, lane-index typedef, default widths.
//  One sub-module: axis_word_reg (single-entry AXIS output register, load/hold/clear,
//   exposes out_free). Lane counter, accumulator, flush logic, counters live in top.
// TESTING
//  1) 16 pixels 0x0001..0x0010, tuser on first, ready=1 -> 2 words: 
//     0x0008_0007_..._0001 tuser=1, 0x0010_..._0009 tuser=0; word_count=2.
//  2) 3 pixels 0xA1..0xA3 then pixel 0xB0 tuser=1 -> word 0x0..0_00A3_00A2_00A1
//     tuser(first)=1; next word lane0=0xB0 tuser=1; flush_count=1.
//  3) word_axis_ready=0 with one word pending, feed 15 more pixels -> 7 accepted,
//     pixel_ready_out low on 8th; pending word stable; release ready -> both drain in order.
//  4) Random valid/ready toggling, 1024 pixels incrementing -> 128 words, scoreboard
//     exact match, no loss/duplication, word_count=128.
//  5) Assert rst_n_in low mid-word (lane_cnt=5) with word pending -> valid=0, counters=0
//     immediately (async); after release next 8 pixels form a clean word.
//  6) tuser on lane-0 pixel (aligned) -> no flush, flush_count unchanged, word tuser=1.

Source files
------------

// File: rtl/pixel_pack_pkg.sv
// Shared widths and lane indexing for the pixel-to-word packer.
package pixel_pack_pkg;

  localparam int PIXEL_WIDTH_DEF = 16;
  localparam int WORD_WIDTH_DEF  = 128;
  localparam int LANES_DEF       = WORD_WIDTH_DEF / PIXEL_WIDTH_DEF;
  localparam int LANE_IDX_W      = (LANES_DEF > 1) ? $clog2(LANES_DEF) : 1;

  typedef logic [LANE_IDX_W-1:0] lane_idx_t;

endpackage

// File: rtl/axis_word_reg.sv
// Single-entry AXIS output register: loads a word, holds it until handoff, then empties.
module axis_word_reg #(
  parameter int WORD_WIDTH = 128
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  load_i,
  input  logic [WORD_WIDTH-1:0] data_i,
  input  logic                  tuser_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [WORD_WIDTH-1:0] data_o,
  output logic                  tuser_o,
  output logic                  out_free_o
);

  logic                  valid_q, valid_d;
  logic [WORD_WIDTH-1:0] data_q, data_d;
  logic                  tuser_q, tuser_d;

  // The producer only asserts load_i while out_free_o is high, so no word is ever overwritten.
  assign out_free_o = !valid_q || ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    tuser_d = tuser_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      tuser_d = tuser_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      tuser_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      tuser_q <= tuser_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign tuser_o = tuser_q;

endmodule

// File: rtl/pixel_word_packer.sv
// Packs pixels LSB-lane-first into words; a frame start mid-word flushes a zero-padded partial word.
module pixel_word_packer
  import pixel_pack_pkg::*;
#(
  parameter int PIXEL_WIDTH = PIXEL_WIDTH_DEF,
  parameter int WORD_WIDTH  = WORD_WIDTH_DEF
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic [PIXEL_WIDTH-1:0] pixel_data_in,
  input  logic                   pixel_tuser_in,
  input  logic                   pixel_valid_in,
  output logic                   pixel_ready_out,
  output logic [WORD_WIDTH-1:0]  word_axis_data,
  output logic                   word_axis_tuser,
  output logic                   word_axis_valid,
  input  logic                   word_axis_ready,
  output logic [15:0]            flush_count_out,
  output logic [31:0]            word_count_out
);

  localparam int LANES = WORD_WIDTH / PIXEL_WIDTH;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  logic [LW-1:0]         lane_cnt_q, lane_cnt_d;
  logic [WORD_WIDTH-1:0] acc_q, acc_d, load_data;
  logic                  acc_tuser_q, acc_tuser_d, load_tuser;
  logic                  ready_en_q;
  logic [15:0]           flush_cnt_q, flush_cnt_d;
  logic [31:0]           word_cnt_q, word_cnt_d;
  logic                  out_free, accept, last_lane, lane_zero;
  logic                  do_flush, do_complete, load, handoff;

  assign last_lane = (lane_cnt_q == LAST_LANE);
  assign lane_zero = (lane_cnt_q == '0);

  // Only stall when this accept would have to emit a word into a busy output register.
  assign pixel_ready_out = ready_en_q &&
                           (out_free || (!last_lane && !pixel_tuser_in) || lane_zero);

  assign accept      = pixel_valid_in && pixel_ready_out;
  assign do_flush    = accept && pixel_tuser_in && !lane_zero;
  assign do_complete = accept && last_lane && !do_flush;
  assign load        = do_flush || do_complete;
  assign handoff     = word_axis_valid && word_axis_ready;

  always_comb begin
    acc_d       = acc_q;
    acc_tuser_d = acc_tuser_q;
    lane_cnt_d  = lane_cnt_q;
    load_data   = acc_q;
    load_tuser  = acc_tuser_q;
    if (do_flush) begin
      // Partial word leaves as-is (unused lanes are already zero); new frame starts at lane 0.
      acc_d                    = '0;
      acc_d[PIXEL_WIDTH-1:0]   = pixel_data_in;
      acc_tuser_d              = 1'b1;
      lane_cnt_d               = LW'(1);
    end else if (accept) begin
      acc_d[lane_cnt_q*PIXEL_WIDTH +: PIXEL_WIDTH] = pixel_data_in;
      if (lane_zero) begin
        acc_tuser_d = pixel_tuser_in;
      end
      if (last_lane) begin
        load_data   = acc_d;
        load_tuser  = acc_tuser_d;
        acc_d       = '0;
        acc_tuser_d = 1'b0;
        lane_cnt_d  = '0;
      end else begin
        lane_cnt_d = lane_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    flush_cnt_d = flush_cnt_q;
    word_cnt_d  = word_cnt_q;
    if (do_flush && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
    if (handoff) begin
      word_cnt_d = word_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      lane_cnt_q  <= '0;
      acc_q       <= '0;
      acc_tuser_q <= 1'b0;
      ready_en_q  <= 1'b0;
      flush_cnt_q <= '0;
      word_cnt_q  <= '0;
    end else begin
      lane_cnt_q  <= lane_cnt_d;
      acc_q       <= acc_d;
      acc_tuser_q <= acc_tuser_d;
      ready_en_q  <= 1'b1;
      flush_cnt_q <= flush_cnt_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  axis_word_reg #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_out_reg (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .load_i    (load),
    .data_i    (load_data),
    .tuser_i   (load_tuser),
    .ready_i   (word_axis_ready),
    .valid_o   (word_axis_valid),
    .data_o    (word_axis_data),
    .tuser_o   (word_axis_tuser),
    .out_free_o(out_free)
  );

  assign flush_count_out = flush_cnt_q;
  assign word_count_out  = word_cnt_q;

endmodule

// File: tb/tb_pixel_word_packer.sv
// Self-checking bench for pixel_word_packer: directed scenarios plus a randomized handshake run.
module tb_pixel_word_packer;
  import pixel_pack_pkg::*;

  localparam int PW = PIXEL_WIDTH_DEF;
  localparam int WW = WORD_WIDTH_DEF;
  localparam int LN = WW / PW;

  logic          clk_in = 1'b0;
  logic          rst_n_in = 1'b0;
  logic [PW-1:0] pixel_data_in = '0;
  logic          pixel_tuser_in = 1'b0;
  logic          pixel_valid_in = 1'b0;
  logic          pixel_ready_out;
  logic [WW-1:0] word_axis_data;
  logic          word_axis_tuser;
  logic          word_axis_valid;
  logic          word_axis_ready = 1'b0;
  logic [15:0]   flush_count_out;
  logic [31:0]   word_count_out;

  pixel_word_packer dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .pixel_data_in  (pixel_data_in),
    .pixel_tuser_in (pixel_tuser_in),
    .pixel_valid_in (pixel_valid_in),
    .pixel_ready_out(pixel_ready_out),
    .word_axis_data (word_axis_data),
    .word_axis_tuser(word_axis_tuser),
    .word_axis_valid(word_axis_valid),
    .word_axis_ready(word_axis_ready),
    .flush_count_out(flush_count_out),
    .word_count_out (word_count_out)
  );

  always #5 clk_in = ~clk_in;

  typedef logic [WW:0] wrec_t;  // {tuser, data}
  wrec_t got_q[$];
  wrec_t exp_q[$];

  logic [WW-1:0] m_word = '0;
  int            m_cnt = 0;
  logic          m_tuser = 1'b0;
  int            n_vec = 0;
  int            n_miscmp = 0;
  logic          rand_done = 1'b0;

  function automatic void model_clear();
    m_word  = '0;
    m_cnt   = 0;
    m_tuser = 1'b0;
  endfunction

  // Reference: gather pixels into groups of LN; a frame start on a non-empty group closes it early.
  function automatic void model_pixel(logic [PW-1:0] d, logic t);
    if (t && m_cnt != 0) begin
      exp_q.push_back({m_tuser, m_word});
      model_clear();
    end
    if (m_cnt == 0) m_tuser = t;
    m_word = m_word | (WW'(d) << (m_cnt * PW));
    m_cnt++;
    if (m_cnt == LN) begin
      exp_q.push_back({m_tuser, m_word});
      model_clear();
    end
  endfunction

  function automatic logic [WW-1:0] pack8(logic [PW-1:0] base);
    logic [WW-1:0] w;
    w = '0;
    for (int i = 0; i < LN; i++) w[i*PW +: PW] = base + PW'(i);
    return w;
  endfunction

  // Inputs change only at posedge+1, so the negedge sees exactly what the next posedge will use.
  always @(negedge clk_in) begin
    if (rst_n_in) begin
      if (pixel_valid_in && pixel_ready_out) model_pixel(pixel_data_in, pixel_tuser_in);
      if (word_axis_valid && word_axis_ready) got_q.push_back({word_axis_tuser, word_axis_data});
    end
  end

  task automatic send_pixel(input logic [PW-1:0] d, input logic t);
    int waited = 0;
    pixel_data_in  = d;
    pixel_tuser_in = t;
    pixel_valid_in = 1'b1;
    @(negedge clk_in);
    while (!pixel_ready_out && waited < 50) begin
      waited++;
      @(negedge clk_in);
    end
    if (!pixel_ready_out) begin
      n_vec++;
      n_miscmp++;
      $display("FAIL send_timeout pixel=%h ready stayed %b, required 1", d, pixel_ready_out);
    end
    @(posedge clk_in);
    #1;
    pixel_valid_in = 1'b0;
    pixel_tuser_in = 1'b0;
  endtask

  task automatic wait_words(input int n);
    int c = 0;
    while (got_q.size() < n && c < 1000) begin
      @(posedge clk_in);
      #1;
      c++;
    end
    if (got_q.size() < n) begin
      n_vec++;
      n_miscmp++;
      $display("FAIL drain_timeout words=%0d required %0d", got_q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    n_vec++; if (word_axis_valid !== 1'b0) begin n_miscmp++; $display("FAIL rst_valid got=%b exp=0", word_axis_valid); end
    n_vec++; if (word_axis_data !== '0) begin n_miscmp++; $display("FAIL rst_data got=%h exp=0", word_axis_data); end
    n_vec++; if (word_axis_tuser !== 1'b0) begin n_miscmp++; $display("FAIL rst_tuser got=%b exp=0", word_axis_tuser); end
    n_vec++; if (flush_count_out !== 16'd0) begin n_miscmp++; $display("FAIL rst_flush got=%0d exp=0", flush_count_out); end
    n_vec++; if (word_count_out !== 32'd0) begin n_miscmp++; $display("FAIL rst_wcount got=%0d exp=0", word_count_out); end
    n_vec++; if (pixel_ready_out !== 1'b0) begin n_miscmp++; $display("FAIL rst_ready got=%b exp=0", pixel_ready_out); end
    rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_sequential();
    got_q.delete();
    exp_q.delete();
    word_axis_ready = 1'b1;
    for (int i = 0; i < 16; i++) send_pixel(PW'(i + 1), i == 0);
    wait_words(2);
    n_vec++; if (got_q.size() != 2) begin n_miscmp++; $display("FAIL seq_count got=%0d exp=2", got_q.size()); end
    if (got_q.size() >= 2) begin
      n_vec++; if (got_q[0] !== {1'b1, pack8(16'h0001)}) begin n_miscmp++; $display("FAIL seq_word0 got=%h exp=%h", got_q[0], {1'b1, pack8(16'h0001)}); end
      n_vec++; if (got_q[1] !== {1'b0, pack8(16'h0009)}) begin n_miscmp++; $display("FAIL seq_word1 got=%h exp=%h", got_q[1], {1'b0, pack8(16'h0009)}); end
    end
    n_vec++; if (word_count_out !== 32'd2) begin n_miscmp++; $display("FAIL seq_wcount got=%0d exp=2", word_count_out); end
    n_vec++; if (flush_count_out !== 16'd0) begin n_miscmp++; $display("FAIL seq_flush got=%0d exp=0", flush_count_out); end
  endtask

  task automatic test_flush();
    logic [15:0] f0;
    got_q.delete();
    exp_q.delete();
    f0 = flush_count_out;
    word_axis_ready = 1'b1;
    send_pixel(16'h00A1, 1'b1);
    send_pixel(16'h00A2, 1'b0);
    send_pixel(16'h00A3, 1'b0);
    send_pixel(16'h00B0, 1'b1);
    for (int i = 1; i < LN; i++) send_pixel(16'h00B0 + PW'(i), 1'b0);
    wait_words(2);
    n_vec++; if (got_q.size() != 2) begin n_miscmp++; $display("FAIL flush_count_words got=%0d exp=2", got_q.size()); end
    if (got_q.size() >= 2) begin
      n_vec++; if (got_q[0] !== {1'b1, 128'h00A3_00A2_00A1}) begin n_miscmp++; $display("FAIL flush_partial got=%h exp=%h", got_q[0], {1'b1, 128'h00A3_00A2_00A1}); end
      n_vec++; if (got_q[1] !== {1'b1, pack8(16'h00B0)}) begin n_miscmp++; $display("FAIL flush_next got=%h exp=%h", got_q[1], {1'b1, pack8(16'h00B0)}); end
    end
    n_vec++; if (flush_count_out - f0 !== 16'd1) begin n_miscmp++; $display("FAIL flush_cnt got=%0d exp=%0d", flush_count_out, f0 + 16'd1); end
  endtask

  task automatic test_backpressure();
    got_q.delete();
    exp_q.delete();
    word_axis_ready = 1'b0;
    for (int i = 0; i < LN; i++) send_pixel(16'h00C0 + PW'(i), 1'b0);
    for (int i = 0; i < LN - 1; i++) send_pixel(16'h00D0 + PW'(i), 1'b0);
    pixel_data_in  = 16'h00D7;
    pixel_tuser_in = 1'b0;
    pixel_valid_in = 1'b1;
    repeat (3) begin
      @(negedge clk_in);
      n_vec++; if (pixel_ready_out !== 1'b0) begin n_miscmp++; $display("FAIL bp_stall_ready got=%b exp=0", pixel_ready_out); end
      n_vec++; if (word_axis_valid !== 1'b1) begin n_miscmp++; $display("FAIL bp_hold_valid got=%b exp=1", word_axis_valid); end
      n_vec++; if (word_axis_data !== pack8(16'h00C0)) begin n_miscmp++; $display("FAIL bp_hold_data got=%h exp=%h", word_axis_data, pack8(16'h00C0)); end
    end
    @(posedge clk_in);
    #1;
    word_axis_ready = 1'b1;
    send_pixel(16'h00D7, 1'b0);
    for (int i = 0; i < LN; i++) send_pixel(16'h00E0 + PW'(i), 1'b0);
    wait_words(3);
    n_vec++; if (got_q.size() != 3) begin n_miscmp++; $display("FAIL bp_words got=%0d exp=3", got_q.size()); end
    if (got_q.size() >= 3) begin
      n_vec++; if (got_q[0] !== {1'b0, pack8(16'h00C0)}) begin n_miscmp++; $display("FAIL bp_word0 got=%h exp=%h", got_q[0], {1'b0, pack8(16'h00C0)}); end
      n_vec++; if (got_q[1] !== {1'b0, pack8(16'h00D0)}) begin n_miscmp++; $display("FAIL bp_word1 got=%h exp=%h", got_q[1], {1'b0, pack8(16'h00D0)}); end
      n_vec++; if (got_q[2] !== {1'b0, pack8(16'h00E0)}) begin n_miscmp++; $display("FAIL bp_word2 got=%h exp=%h", got_q[2], {1'b0, pack8(16'h00E0)}); end
    end
  endtask

  task automatic test_random();
    logic [31:0] wc0;
    logic [15:0] f0;
    got_q.delete();
    exp_q.delete();
    wc0 = word_count_out;
    f0  = flush_count_out;
    rand_done = 1'b0;
    fork
      begin
        while (!rand_done) begin
          word_axis_ready = ($urandom_range(0, 99) < 55);
          @(posedge clk_in);
          #1;
        end
      end
      begin
        for (int i = 0; i < 1024; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) begin
              @(posedge clk_in);
              #1;
            end
          end
          send_pixel(PW'(i + 16'h0100), 1'b0);
        end
        rand_done = 1'b1;
      end
    join
    word_axis_ready = 1'b1;
    wait_words(128);
    n_vec++; if (got_q.size() != 128) begin n_miscmp++; $display("FAIL rnd_words got=%0d exp=128", got_q.size()); end
    for (int i = 0; i < 128; i++) begin
      if (i < got_q.size() && i < exp_q.size()) begin
        n_vec++;
        if (got_q[i] !== exp_q[i]) begin
          n_miscmp++;
          $display("FAIL rnd_word[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
        end
      end
    end
    n_vec++; if (word_count_out - wc0 !== 32'd128) begin n_miscmp++; $display("FAIL rnd_wcount delta=%0d exp=128", word_count_out - wc0); end
    n_vec++; if (flush_count_out !== f0) begin n_miscmp++; $display("FAIL rnd_flush got=%0d exp=%0d", flush_count_out, f0); end
  endtask

  task automatic test_reset_mid();
    word_axis_ready = 1'b0;
    for (int i = 0; i < LN; i++) send_pixel(16'h00F0 + PW'(i), 1'b0);
    for (int i = 0; i < 5; i++) send_pixel(16'h0050 + PW'(i), 1'b0);
    rst_n_in = 1'b0;
    #1;
    n_vec++; if (word_axis_valid !== 1'b0) begin n_miscmp++; $display("FAIL rmid_valid got=%b exp=0", word_axis_valid); end
    n_vec++; if (word_count_out !== 32'd0) begin n_miscmp++; $display("FAIL rmid_wcount got=%0d exp=0", word_count_out); end
    n_vec++; if (flush_count_out !== 16'd0) begin n_miscmp++; $display("FAIL rmid_flush got=%0d exp=0", flush_count_out); end
    n_vec++; if (pixel_ready_out !== 1'b0) begin n_miscmp++; $display("FAIL rmid_ready got=%b exp=0", pixel_ready_out); end
    model_clear();
    got_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;
    word_axis_ready = 1'b1;
    for (int i = 0; i < LN; i++) send_pixel(16'h0070 + PW'(i), 1'b0);
    wait_words(1);
    n_vec++; if (got_q.size() != 1) begin n_miscmp++; $display("FAIL rmid_words got=%0d exp=1", got_q.size()); end
    if (got_q.size() >= 1) begin
      n_vec++; if (got_q[0] !== {1'b0, pack8(16'h0070)}) begin n_miscmp++; $display("FAIL rmid_word got=%h exp=%h", got_q[0], {1'b0, pack8(16'h0070)}); end
    end
    n_vec++; if (word_count_out !== 32'd1) begin n_miscmp++; $display("FAIL rmid_wcount_after got=%0d exp=1", word_count_out); end
  endtask

  task automatic test_aligned_tuser();
    logic [15:0] f0;
    got_q.delete();
    exp_q.delete();
    f0 = flush_count_out;
    word_axis_ready = 1'b1;
    for (int i = 0; i < LN; i++) send_pixel(16'h0090 + PW'(i), i == 0);
    wait_words(1);
    n_vec++; if (got_q.size() != 1) begin n_miscmp++; $display("FAIL align_words got=%0d exp=1", got_q.size()); end
    if (got_q.size() >= 1) begin
      n_vec++; if (got_q[0] !== {1'b1, pack8(16'h0090)}) begin n_miscmp++; $display("FAIL align_word got=%h exp=%h", got_q[0], {1'b1, pack8(16'h0090)}); end
    end
    n_vec++; if (flush_count_out !== f0) begin n_miscmp++; $display("FAIL align_flush got=%0d exp=%0d", flush_count_out, f0); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_flush();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_aligned_tuser();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
